// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mult/div op encodings, sequencer states and
// the R-type funct codes that aludec and the controller decode.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply (acc:shreg shifts
// right) or restoring divide (acc = partial remainder, shreg = quotient bits).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum        = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    shifted    = {acc, shreg[WIDTH-1]};
    diff       = shifted - {1'b0, opnd};
    acc_next   = sum[WIDTH:1];
    shreg_next = {sum[0], shreg[WIDTH-1:1]};
    if (is_div) begin
      // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
      if (!diff[WIDTH]) begin
        acc_next   = diff[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next   = shifted[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers.
// Optional build macro MULDIV_EARLY_TERM_EN ends multiplies once the multiplier is exhausted.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic [WIDTH-1:0]    wdata,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output muldiv_state_t       state
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sh_q, opnd_q, hi_q, lo_q;
  logic [WIDTH-1:0] acc_n, sh_n, a_mag, b_mag, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0] cnt_q;
  logic neg_q, rneg_q, is_div, is_signed, a_neg, b_neg, accept, last_step;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy      = (state_q == LOAD) || (state_q == ITER) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state     = state_q;

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] mq_q;
  assign last_step = (cnt_q == '0) || (!is_div && ((mq_q >> 1) == '0));
`else
  assign last_step = (cnt_q == '0);
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div     (is_div),
    .acc        (acc_q),
    .shreg      (sh_q),
    .opnd       (opnd_q),
    .acc_next   (acc_n),
    .shreg_next (sh_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (last_step) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
      mq_q   <= '0;
`endif
    end else begin
      if (accept) begin
        op_q <= muldiv_op_t'(op);
        a_q  <= a;
        b_q  <= b;
      end
      case (state_q)
        LOAD: begin
          acc_q  <= '0;
          sh_q   <= is_div ? a_mag : b_mag;
          opnd_q <= is_div ? b_mag : a_mag;
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          cnt_q  <= CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_TERM_EN
          mq_q   <= b_mag;
`endif
        end
        ITER: begin
          acc_q <= acc_n;
          sh_q  <= sh_n;
          // Counter holds on exit so FIX knows how many zero-add shifts were skipped.
          if (!last_step) cnt_q <= cnt_q - CW'(1);
`ifdef MULDIV_EARLY_TERM_EN
          mq_q  <= mq_q >> 1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod = {acc_q, sh_q};
`ifdef MULDIV_EARLY_TERM_EN
    prod = prod >> cnt_q;
`endif
    fix_hi = '0;
    fix_lo = '0;
    if (!is_div) begin
      {fix_hi, fix_lo} = neg_q ? -prod : prod;
    end else if (b_q == '0) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_lo = neg_q ? -sh_q : sh_q;
      fix_hi = rneg_q ? -acc_q : acc_q;
    end
  end

  // FIX is always busy, so results and MTHI/MTLO writes never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FIX) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (!busy) begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reference model fills an expected queue
// at start, results are popped and compared when done pulses.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic hi_we = 1'b0;
  logic lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  muldiv_state_t state;

  logic [2*W-1:0] exp_q[$];
  logic [1:0] op_q[$];
  logic [W-1:0] model_hi = '0, model_lo = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .state (state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    p = '0;
    case (o)
      2'b00: begin q = sx * sy; p = q; end
      2'b01: p = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Drive one start cycle; caller is at a negedge (IDLE or DONE cycle).
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    exp_q.push_back(ref_result(o, x, y));
    op_q.push_back(o);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask

  // Returns at the negedge where done is high, with hi/lo checked.
  task automatic wait_done(input string tag);
    int budget;
    int lat;
    logic busy_ok;
    logic [63:0] e;
    logic [1:0] o;
    budget = 0;
    busy_ok = 1'b1;
    while (budget < 200) begin
      @(negedge clk);
      budget++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_timeout"}, 64'(done), 64'd1);
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    lat = cyc - start_cyc;
    o = (op_q.size() > 0) ? op_q.pop_front() : 2'b00;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) check({tag, "_latency_max"}, 64'(lat <= W + 2), 64'd1);
    else       check({tag, "_latency"}, 64'(lat), 64'(W + 2));
`else
    check({tag, "_latency"}, 64'(lat), 64'(W + 2));
`endif
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, e);
      model_hi = e[63:32];
      model_lo = e[31:0];
    end else begin
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
    end
  endtask

  initial begin
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Largest unsigned product.
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    @(negedge clk);

    // Signed mixed-sign multiply and divide.
    start_op(OP_MULT, 32'hFFFF_FFF9, 32'd6);
    wait_done("mult_neg");
    @(negedge clk);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg");
    @(negedge clk);

    // Divide by zero and the overflow corner.
    start_op(OP_DIVU, 32'd100, 32'd0);
    wait_done("divu_zero");
    @(negedge clk);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");
    @(negedge clk);

    // Second start and MTHI while busy are ignored; then back-to-back from DONE.
    start_op(OP_MULTU, 32'h8765_4321, 32'hF00D_BEEF);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op = OP_DIV;
    a = 32'd50;
    b = 32'd3;
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    check("busy_write_ignored", 64'(hi), 64'(model_hi));
    wait_done("ignore_start");
    start_op(OP_DIVU, 32'd1000, 32'd7);
    check("b2b_load_state", 64'(state), 64'(LOAD));
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b");
    @(negedge clk);

    // Asynchronous reset mid-iteration.
    start_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (11) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_done", 64'(done), 64'd0);
    check("areset_hilo", {hi, lo}, 64'd0);
    void'(exp_q.pop_back());
    void'(op_q.pop_back());
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_op(OP_MULTU, 32'd3, 32'd5);
    wait_done("after_reset");
    @(negedge clk);

    // MTHI / MTLO while idle.
    hi_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    check("mthi_lo_kept", 64'(lo), 64'(model_lo));
    model_hi = 32'hA5A5_A5A5;
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h5A5A_0F0F;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0000_0000_5A5A_0F0F);
    check("mtlo_hi_kept", 64'(hi), 64'(model_hi));
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mt_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
    @(negedge clk);

    // Write in the start cycle is overwritten by the result.
    hi_we = 1'b1;
    wdata = 32'h1111_2222;
    start_op(OP_MULTU, 32'd5, 32'd0);
    hi_we = 1'b0;
    wait_done("zero_mul");
    @(negedge clk);

    // Random operations, sometimes chained straight from DONE.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] ro;
      logic [W-1:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      start_op(ro, rx, ry);
      wait_done($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
